// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues in-order word reads to
// instruction memory, buffers returned words and hands them to decode with a
// valid/ready handshake. A redirect flushes the buffer and discards responses
// that were already in flight when it happened.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        Clk,
  input  logic        Reset_n,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemGnt,
  input  logic        IMemRValid,
  input  logic [31:0] IMemRData,
  output logic        InstrValid,
  output logic [31:0] Instr,
  output logic [31:0] InstrPC,
  output logic [31:0] PCPlus4,
  input  logic        InstrReady,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC
);

  // Counters hold at most FIFO_DEPTH (<= 8), so four bits are always enough.
  localparam int CW = 4;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [31:0]     pc;
  logic [31:0]     resp_pc;
  logic [CW-1:0]   inflight;
  logic [CW-1:0]   drop;
  logic [CW-1:0]   count;
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [31:0]     data_mem [FIFO_DEPTH];
  logic [31:0]     pc_mem   [FIFO_DEPTH];
  logic            credit_ok;
  logic            issue;
  logic            rsp;
  logic            push;
  logic            consume;
  logic            redirect_run;
  logic [31:0]     redirect_addr;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // A new request may go out only while words in flight plus buffered words
  // leave room in the buffer, using registered counts only.
  assign credit_ok     = ({1'b0, inflight} + {1'b0, count}) < DEPTH_C;
  assign issue         = IMemReq & IMemGnt;
  assign rsp           = IMemRValid & (inflight != '0);
  assign redirect_run  = Redirect & (state == RUN);
  assign push          = rsp & (drop == '0) & ~redirect_run;
  assign consume       = InstrValid & InstrReady;
  assign redirect_addr = RedirectPC & ~32'h3;

  assign IMemAddr   = pc;
  assign InstrValid = (count != '0);
  assign Instr      = data_mem[head];
  assign InstrPC    = pc_mem[head];
  assign PCPlus4    = InstrPC + 32'd4;

  // State register: one IDLE cycle after reset, then RUN forever.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and the request strobe, which is only raised in RUN.
  always_comb begin
    state_next = state;
    IMemReq    = 1'b0;
    case (state)
      IDLE: state_next = RUN;
      RUN:  IMemReq    = credit_ok;
      default: state_next = IDLE;
    endcase
  end

  // Fetch PC, the PC tag for the next accepted response, and the in-flight and
  // stale-response counters; a redirect turns everything in flight into drops.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pc       <= RESET_PC;
      resp_pc  <= RESET_PC;
      inflight <= '0;
      drop     <= '0;
    end else begin
      inflight <= inflight + CW'(issue) - CW'(rsp);
      if (Redirect) begin
        pc      <= redirect_addr;
        resp_pc <= redirect_addr;
      end else begin
        if (issue) begin
          pc <= pc + 32'd4;
        end
        if (push) begin
          resp_pc <= resp_pc + 32'd4;
        end
      end
      if (redirect_run) begin
        drop <= inflight - CW'(rsp) + CW'(issue);
      end else if (rsp && (drop != '0)) begin
        drop <= drop - CW'(1);
      end
    end
  end

  // Instruction buffer: push accepted responses, pop on consume, clear on redirect.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        data_mem[i] <= '0;
        pc_mem[i]   <= '0;
      end
    end else if (redirect_run) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        data_mem[tail] <= IMemRData;
        pc_mem[tail]   <= resp_pc;
        tail           <= ptr_inc(tail);
      end
      if (consume) begin
        head <= ptr_inc(head);
      end
      count <= count + CW'(push) - CW'(consume);
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: memory responder with an in-order queue,
// program-order reference model for fetch addresses and delivered
// instructions, directed scenarios plus a randomized phase.
module tb_instr_fetch_unit;

  localparam int          DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemGnt = 1'b0;
  logic        IMemRValid = 1'b0;
  logic [31:0] IMemRData = '0;
  logic        InstrValid;
  logic [31:0] Instr;
  logic [31:0] InstrPC;
  logic [31:0] PCPlus4;
  logic        InstrReady = 1'b0;
  logic        Redirect = 1'b0;
  logic [31:0] RedirectPC = '0;

  instr_fetch_unit #(
    .RESET_PC   (RST_PC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .IMemReq    (IMemReq),
    .IMemAddr   (IMemAddr),
    .IMemGnt    (IMemGnt),
    .IMemRValid (IMemRValid),
    .IMemRData  (IMemRData),
    .InstrValid (InstrValid),
    .Instr      (Instr),
    .InstrPC    (InstrPC),
    .PCPlus4    (PCPlus4),
    .InstrReady (InstrReady),
    .Redirect   (Redirect),
    .RedirectPC (RedirectPC)
  );

  // Free-running clock.
  always #5 Clk = ~Clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          n_issue  = 0;
  int          n_cons   = 0;
  logic [31:0] mem_addr_q [$];
  int          mem_edge_q [$];
  logic [31:0] cons_log   [$];
  logic [31:0] exp_fetch  = RST_PC;
  logic [31:0] exp_pc     = RST_PC;
  bit          chk_flush    = 1'b0;
  bit          hold_pending = 1'b0;
  logic [31:0] hold_addr    = '0;
  bit          rand_mode  = 1'b0;
  bit          mem_hold   = 1'b0;
  bit          gnt_knob   = 1'b0;
  bit          ready_knob = 1'b0;
  bit          redir_req  = 1'b0;
  logic [31:0] redir_tgt  = '0;
  int          resp_pct   = 100;

  // Contents of instruction memory as a pure function of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference model, evaluated at the falling edge on the values that the
  // next rising edge will act upon.
  task automatic observe();
    logic [31:0] tgt;
    if (!Reset_n) return;
    if (chk_flush) begin
      checkOutput("flush_valid", 32'(InstrValid), 32'd0);
      chk_flush = 1'b0;
    end
    if (hold_pending) begin
      checkOutput("hold_req", 32'(IMemReq), 32'd1);
      checkOutput("hold_addr", IMemAddr, hold_addr);
    end
    hold_pending = IMemReq && !IMemGnt && !Redirect;
    hold_addr    = IMemAddr;
    if (IMemReq && IMemGnt) begin
      checkOutput("issue_addr", IMemAddr, exp_fetch);
      mem_addr_q.push_back(IMemAddr);
      mem_edge_q.push_back(cyc + 1);
      checkOutput("credit", 32'(mem_addr_q.size() <= DEPTH), 32'd1);
      exp_fetch = exp_fetch + 32'd4;
      n_issue++;
    end
    if (InstrValid && InstrReady) begin
      checkOutput("instr_pc", InstrPC, exp_pc);
      checkOutput("instr", Instr, mem_word(exp_pc));
      checkOutput("pc_plus4", PCPlus4, exp_pc + 32'd4);
      cons_log.push_back(InstrPC);
      exp_pc = exp_pc + 32'd4;
      n_cons++;
    end
    if (Redirect) begin
      tgt       = {RedirectPC[31:2], 2'b00};
      exp_fetch = tgt;
      exp_pc    = tgt;
      chk_flush = 1'b1;
    end
  endtask

  // One clock: drive memory response and control inputs just after the
  // rising edge, then run the model at the falling edge.
  task automatic applyStimulus();
    @(posedge Clk);
    #1;
    cyc++;
    if (mem_addr_q.size() > 0 && !mem_hold && mem_edge_q[0] <= cyc &&
        $urandom_range(99) < resp_pct) begin
      IMemRValid = 1'b1;
      IMemRData  = mem_word(mem_addr_q.pop_front());
      void'(mem_edge_q.pop_front());
    end else begin
      IMemRValid = 1'b0;
      IMemRData  = $urandom;
    end
    if (rand_mode) begin
      IMemGnt    = ($urandom_range(3) != 0);
      InstrReady = ($urandom_range(9) < 7);
      Redirect   = ($urandom_range(99) < 3);
      RedirectPC = $urandom;
    end else begin
      IMemGnt    = gnt_knob;
      InstrReady = ready_knob;
      Redirect   = redir_req;
      RedirectPC = redir_tgt;
      redir_req  = 1'b0;
    end
    @(negedge Clk);
    observe();
  endtask

  // Reset DUT, memory and model together; release away from the rising edge.
  task automatic do_reset();
    Reset_n    = 1'b0;
    rand_mode  = 1'b0;
    gnt_knob   = 1'b0;
    ready_knob = 1'b0;
    redir_req  = 1'b0;
    mem_hold   = 1'b0;
    resp_pct   = 100;
    IMemRValid = 1'b0;
    IMemGnt    = 1'b0;
    InstrReady = 1'b0;
    Redirect   = 1'b0;
    mem_addr_q.delete();
    mem_edge_q.delete();
    cons_log.delete();
    exp_fetch    = RST_PC;
    exp_pc       = RST_PC;
    chk_flush    = 1'b0;
    hold_pending = 1'b0;
    n_issue      = 0;
    n_cons       = 0;
    repeat (2) applyStimulus();
    #2;
    Reset_n = 1'b1;
  endtask

  // Step until the next issue and compare its address.
  task automatic wait_req(input string tag, input logic [31:0] exp);
    int n = 0;
    applyStimulus();
    while (!(IMemReq && IMemGnt) && n < 30) begin
      applyStimulus();
      n++;
    end
    checkOutput({tag, "_seen"}, 32'(IMemReq && IMemGnt), 32'd1);
    checkOutput(tag, IMemAddr, exp);
  endtask

  // Hard time limit so the run always ends.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Test sequence.
  initial begin
    int c0;

    $display("[TB] reset and first fetch");
    do_reset();
    checkOutput("rst_req", 32'(IMemReq), 32'd0);
    checkOutput("rst_addr", IMemAddr, RST_PC);
    checkOutput("rst_valid", 32'(InstrValid), 32'd0);
    checkOutput("rst_pcplus4", PCPlus4, 32'd4);
    gnt_knob   = 1'b1;
    ready_knob = 1'b1;
    applyStimulus();
    checkOutput("t1_req0", 32'(IMemReq), 32'd1);
    checkOutput("t1_addr0", IMemAddr, 32'h0);
    checkOutput("t1_valid0", 32'(InstrValid), 32'd0);
    applyStimulus();
    checkOutput("t1_req1", 32'(IMemReq), 32'd1);
    checkOutput("t1_addr1", IMemAddr, 32'h4);
    checkOutput("t1_valid1", 32'(InstrValid), 32'd0);
    applyStimulus();
    checkOutput("t1_valid2", 32'(InstrValid), 32'd1);
    checkOutput("t1_pc2", InstrPC, 32'h0);
    checkOutput("t1_instr2", Instr, mem_word(32'h0));
    repeat (20) applyStimulus();
    checkOutput("t1_progress", 32'(n_cons >= 5), 32'd1);

    $display("[TB] decode stalled");
    do_reset();
    gnt_knob   = 1'b1;
    ready_knob = 1'b0;
    repeat (8) applyStimulus();
    checkOutput("t2_issues", 32'(n_issue), 32'd2);
    checkOutput("t2_req_low", 32'(IMemReq), 32'd0);
    checkOutput("t2_valid", 32'(InstrValid), 32'd1);
    ready_knob = 1'b1;
    repeat (6) applyStimulus();
    checkOutput("t2_first", (cons_log.size() > 0) ? cons_log[0] : 32'hDEAD_BEEF, 32'h0);
    checkOutput("t2_second", (cons_log.size() > 1) ? cons_log[1] : 32'hDEAD_BEEF, 32'h4);

    $display("[TB] grant withheld");
    do_reset();
    gnt_knob   = 1'b1;
    ready_knob = 1'b1;
    for (int i = 0; i < 20 && n_issue < 2; i++) applyStimulus();
    gnt_knob = 1'b0;
    applyStimulus();
    for (int i = 0; i < 20 && !IMemReq; i++) applyStimulus();
    checkOutput("t3_req", 32'(IMemReq), 32'd1);
    checkOutput("t3_addr", IMemAddr, 32'h8);
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checkOutput("t3_hold_req", 32'(IMemReq), 32'd1);
      checkOutput("t3_hold_addr", IMemAddr, 32'h8);
    end
    gnt_knob = 1'b1;
    repeat (6) applyStimulus();

    $display("[TB] redirect with words in flight");
    do_reset();
    gnt_knob   = 1'b1;
    ready_knob = 1'b1;
    mem_hold   = 1'b1;
    for (int i = 0; i < 10 && mem_addr_q.size() < 2; i++) applyStimulus();
    checkOutput("t4_outstanding", 32'(mem_addr_q.size()), 32'd2);
    redir_req = 1'b1;
    redir_tgt = 32'h0000_0100;
    applyStimulus();
    mem_hold = 1'b0;
    applyStimulus();
    for (int i = 0; i < 20 && !InstrValid; i++) applyStimulus();
    checkOutput("t4_valid", 32'(InstrValid), 32'd1);
    checkOutput("t4_pc", InstrPC, 32'h0000_0100);
    checkOutput("t4_pcplus4", PCPlus4, 32'h0000_0104);
    checkOutput("t4_instr", Instr, mem_word(32'h0000_0100));

    $display("[TB] unaligned redirect");
    redir_req = 1'b1;
    redir_tgt = 32'h0000_0043;
    applyStimulus();
    wait_req("t5_addr", 32'h0000_0040);

    $display("[TB] redirect at top of address space");
    redir_req = 1'b1;
    redir_tgt = 32'hFFFF_FFFC;
    applyStimulus();
    wait_req("t6_top", 32'hFFFF_FFFC);
    wait_req("t6_wrap", 32'h0000_0000);
    repeat (8) applyStimulus();

    $display("[TB] randomized traffic");
    do_reset();
    rand_mode = 1'b1;
    resp_pct  = 60;
    c0        = n_cons;
    repeat (3000) applyStimulus();
    rand_mode = 1'b0;
    checkOutput("rand_progress", 32'((n_cons - c0) > 100), 32'd1);

    $display("[TB] reset pulse mid-stream");
    gnt_knob   = 1'b1;
    ready_knob = 1'b1;
    repeat (5) applyStimulus();
    #2;
    Reset_n = 1'b0;
    #1;
    checkOutput("t7_req", 32'(IMemReq), 32'd0);
    checkOutput("t7_addr", IMemAddr, RST_PC);
    checkOutput("t7_valid", 32'(InstrValid), 32'd0);
    checkOutput("t7_instr", Instr, 32'h0);
    checkOutput("t7_pc", InstrPC, 32'h0);
    checkOutput("t7_pcplus4", PCPlus4, 32'd4);
    do_reset();
    gnt_knob   = 1'b1;
    ready_knob = 1'b1;
    wait_req("t7_restart", RST_PC);
    repeat (6) applyStimulus();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
